// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler driving a shared bit-serial adder; returns {carry,sum} with the requester id.
// Latency: rsp_valid rises W+1 clocks after the accepting edge; minimum issue interval is W+3 clocks.
// Backpressure: the result is held in DONE until rsp_ready; no request is accepted outside IDLE.
module serial_add_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   req_ready,
    output logic         sa_a,
    output logic         sa_b,
    output logic         sa_en,
    output logic         sa_clr,
    input  logic         sa_sum,
    input  logic         sa_cy,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cy,
    input  logic         rsp_ready
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           rr_q;
    logic           id_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   op_a_q, op_b_q, sum_q, sum_nx;
    logic           grant;
    logic           accept;
    logic           shift_last;

    // Round-robin only matters on contention; otherwise the sole requester wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) grant = rr_q;
        else                    grant = ~req_valid[0];
    end

    always_comb begin
        req_ready = 2'b00;
        if (state_q == S_IDLE && !rst && (req_valid != 2'b00)) req_ready[grant] = 1'b1;
    end

    assign accept     = (req_ready != 2'b00);
    assign shift_last = (cnt_q == CW'(W - 1));

    // Serial sum bit enters at the MSB so bit 0 ends up holding the first bit produced.
    always_comb begin
        sum_nx        = sum_q >> 1;
        sum_nx[W-1]   = sa_sum;
    end

    always_comb begin
        state_d   = state_q;
        sa_a      = 1'b0;
        sa_b      = 1'b0;
        sa_en     = 1'b0;
        sa_clr    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CLR;
            S_CLR: begin
                sa_clr  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sa_en = 1'b1;
                sa_a  = op_a_q[0];
                sa_b  = op_b_q[0];
                if (shift_last) state_d = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_id  = id_q;
    assign rsp_sum = (state_q == S_DONE) ? sum_q : '0;
    assign rsp_cy  = (state_q == S_DONE) & sa_cy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_q <= grant ? req_a1 : req_a0;
                        op_b_q <= grant ? req_b1 : req_b0;
                        id_q   <= grant;
                        rr_q   <= ~grant;
                        sum_q  <= '0;
                    end
                end
                S_CLR: cnt_q <= '0;
                S_SHIFT: begin
                    sum_q  <= sum_nx;
                    op_a_q <= op_a_q >> 1;
                    op_b_q <= op_b_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched with a behavioural model of the serial adder.
module tb_serial_add_sched;
    localparam int W = 4;

    typedef struct packed {
        logic         id;
        logic [W:0]   total;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   req_ready;
    logic         sa_a, sa_b, sa_en, sa_clr, sa_sum, sa_cy;
    logic         rsp_valid, rsp_id, rsp_cy, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         carry;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_add_sched #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready),
        .sa_a(sa_a), .sa_b(sa_b), .sa_en(sa_en), .sa_clr(sa_clr),
        .sa_sum(sa_sum), .sa_cy(sa_cy),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cy(rsp_cy),
        .rsp_ready(rsp_ready)
    );

    // Adder with registered carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         carry <= 1'b0;
        else if (sa_clr) carry <= 1'b0;
        else if (sa_en)  carry <= (sa_a & sa_b) | (carry & (sa_a ^ sa_b));
    end
    assign sa_sum = sa_a ^ sa_b ^ carry;
    assign sa_cy  = carry;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {req_ready, sa_a, sa_b, sa_en, sa_clr, rsp_valid, rsp_id, rsp_sum, rsp_cy}, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is presented.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d sum=%0h cy=%0d expected no response",
                         rsp_id, rsp_sum, rsp_cy);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_cy_sum", 32'({rsp_cy, rsp_sum}), 32'(e.total));
            end
        end
    end

    // Waits for the next grant, checks it targets exp_id, and records the expected result.
    task automatic wait_accept(input string name, input logic exp_id, input logic [W:0] exp_total);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_t e;
                check(name, 32'(req_ready), exp_id ? 32'h2 : 32'h1);
                e.id    = exp_id;
                e.total = exp_total;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no grant expected grant to %0d", name, exp_id);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

        // T1: reset behaviour
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("t1_in_reset");
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t1_midcycle_rst");
        req_valid = 2'b01; req_a0 = 4'd3; req_b0 = 4'd5;
        #1;
        check("t1_ready_in_rst", 32'(req_ready), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t1_ready_after_rst", 32'(req_ready), 32'h1);

        // T2: 3+5, response exactly W+1 clocks after the accepting edge
        wait_accept("t2_grant", 1'b0, 5'h08);
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        check("t2_valid_early", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        check("t2_valid_on_time", 32'(rsp_valid), 32'h1);
        drain("t2");

        // T3: requester 1, wrap into carry
        req_valid = 2'b10; req_a1 = 4'd15; req_b1 = 4'd1;
        wait_accept("t3a_grant", 1'b1, 5'h10);
        req_a1 = 4'd15; req_b1 = 4'd15;
        wait_accept("t3b_grant", 1'b1, 5'h1E);
        req_valid = 2'b00;
        drain("t3");

        // T4: both requesting, grants alternate 0,1,0
        req_valid = 2'b11; req_a0 = 4'd2; req_b0 = 4'd7; req_a1 = 4'd6; req_b1 = 4'd4;
        wait_accept("t4_g0", 1'b0, 5'h09);
        req_a0 = 4'd12; req_b0 = 4'd9;
        wait_accept("t4_g1", 1'b1, 5'h0A);
        wait_accept("t4_g2", 1'b0, 5'h15);
        req_valid = 2'b00;
        drain("t4");

        // T5: response backpressure with a pending request
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_a0 = 4'd4; req_b0 = 4'd4;
        wait_accept("t5_grant", 1'b0, 5'h08);
        req_a0 = 4'd1; req_b0 = 4'd1;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", 32'(rsp_valid), 32'h1);
            check("t5_hold_rsp", 32'({rsp_id, rsp_cy, rsp_sum}), 32'h08);
            check("t5_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_no_accept_on_rsp", 32'(req_ready), 32'h0);
        wait_accept("t5_next_grant", 1'b0, 5'h02);
        req_valid = 2'b00;
        drain("t5");

        // T6: reset during SHIFT bit 2 drops the add
        req_valid = 2'b01; req_a0 = 4'd7; req_b0 = 4'd7;
        wait_accept("t6_grant", 1'b0, 5'h0E);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst_outputs");
        exp_q.delete();
        #3;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 2'b01; req_a0 = 4'd9; req_b0 = 4'd6;
        wait_accept("t6_fresh_grant", 1'b0, 5'h0F);
        req_valid = 2'b00;
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
